adbg_toggle_sync_array: RTL and testbench



---
 rtl/adbg_sync_pkg.sv | 12 +
 rtl/adbg_toggle_sync_array_if.sv | 48 ++++
 rtl/adbg_sync_chan.sv | 69 ++++++
 rtl/adbg_toggle_sync_array.sv | 58 +++++
 tb/tb_adbg_toggle_sync_array.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_sync_pkg.sv
// rtl/adbg_sync_pkg.sv - shared constants and helpers for the toggle synchroniser array
package adbg_sync_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int CNT_W_DEFAULT   = 8;

   // Arm counter must reach SYNC_STAGES+1 so the chain and prev hold post-reset levels
   function automatic int arm_cnt_w(input int sync_stages);
      return $clog2(sync_stages + 2);
   endfunction

endpackage

// File: rtl/adbg_toggle_sync_array_if.sv
// rtl/adbg_toggle_sync_array_if.sv - event bus of the toggle synchroniser array (EVCNT gated by ADBG_SYNC_EVCNT_EN)
interface adbg_toggle_sync_array_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
);

   logic [CHANNELS-1:0] TOGGLE_IN;
   logic [CHANNELS-1:0] D_SET;
   logic [CHANNELS-1:0] D_RST;
   logic [CHANNELS-1:0] D_OUT;
   logic [CHANNELS-1:0] PULSE_OUT;
   logic [CHANNELS-1:0] OVERFLOW;
   logic                READY;
`ifdef ADBG_SYNC_EVCNT_EN
   logic [CHANNELS*CNT_W-1:0] EVCNT;
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("adbg_toggle_sync_array_if: CNT_W must be >= 1");
   end

   modport master (
      output TOGGLE_IN,
      output D_SET,
      output D_RST,
      input  D_OUT,
      input  PULSE_OUT,
      input  OVERFLOW,
`ifdef ADBG_SYNC_EVCNT_EN
      input  EVCNT,
`endif
      input  READY
   );

   modport slave (
      input  TOGGLE_IN,
      input  D_SET,
      input  D_RST,
      output D_OUT,
      output PULSE_OUT,
      output OVERFLOW,
`ifdef ADBG_SYNC_EVCNT_EN
      output EVCNT,
`endif
      output READY
   );

endinterface

// File: rtl/adbg_sync_chan.sv
// rtl/adbg_sync_chan.sv - one toggle channel: sync chain, edge detect, sticky/overflow flags, optional counter (ADBG_SYNC_EVCNT_EN)
module adbg_sync_chan
   import adbg_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic             DEST_CLK,
   input  logic             RESET,
   input  logic             ready,
   input  logic             toggle,
   input  logic             d_set,
   input  logic             d_rst,
   output logic             d_out,
   output logic             pulse_out,
`ifdef ADBG_SYNC_EVCNT_EN
   output logic [CNT_W-1:0] evcnt,
`endif
   output logic             overflow
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;
   logic                   sticky;
   logic                   ovf;
   logic                   det;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("adbg_sync_chan: CNT_W must be >= 1");
   end

   // prev keeps tracking while not ready so the first armed cycle sees no stale edge
   assign det = (chain[SYNC_STAGES-1] ^ prev) & ready;

   always_ff @(posedge DEST_CLK) begin
      if (RESET) begin
         chain  <= '0;
         prev   <= 1'b0;
         sticky <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         chain  <= {chain[SYNC_STAGES-2:0], toggle};
         prev   <= chain[SYNC_STAGES-1];
         sticky <= det | (sticky & ~d_rst) | (d_set & ~d_rst);
         ovf    <= (det & sticky & ~d_rst) | (ovf & ~d_rst);
      end
   end

`ifdef ADBG_SYNC_EVCNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge DEST_CLK) begin
      if (RESET) begin
         cnt <= '0;
      end else if (d_rst) begin
         cnt <= det ? CNT_W'(1) : '0;
      end else if (det && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign evcnt = cnt;
`endif

   assign d_out     = sticky | det;
   assign pulse_out = det;
   assign overflow  = ovf;

endmodule

// File: rtl/adbg_toggle_sync_array.sv
// rtl/adbg_toggle_sync_array.sv - multi-channel toggle-to-event synchroniser; ADBG_SYNC_EVCNT_EN adds per-channel event counters
module adbg_toggle_sync_array
   import adbg_sync_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic                     DEST_CLK,
   input  logic                     RESET,
   adbg_toggle_sync_array_if.slave  bus
);

   localparam int ARM_W = arm_cnt_w(SYNC_STAGES);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
      $error("adbg_toggle_sync_array: SYNC_STAGES must be >= 2");
   end
   if (CHANNELS < 1) begin : g_bad_channels
      $error("adbg_toggle_sync_array: CHANNELS must be >= 1");
   end

   logic [ARM_W-1:0] arm_cnt;
   logic             ready;

   always_ff @(posedge DEST_CLK) begin
      if (RESET) begin
         arm_cnt <= '0;
      end else if (arm_cnt != ARM_DONE) begin
         arm_cnt <= arm_cnt + 1'b1;
      end
   end

   assign ready     = (arm_cnt == ARM_DONE);
   assign bus.READY = ready;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      adbg_sync_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_chan (
         .DEST_CLK  (DEST_CLK),
         .RESET     (RESET),
         .ready     (ready),
         .toggle    (bus.TOGGLE_IN[i]),
         .d_set     (bus.D_SET[i]),
         .d_rst     (bus.D_RST[i]),
         .d_out     (bus.D_OUT[i]),
         .pulse_out (bus.PULSE_OUT[i]),
`ifdef ADBG_SYNC_EVCNT_EN
         .evcnt     (bus.EVCNT[i*CNT_W +: CNT_W]),
`endif
         .overflow  (bus.OVERFLOW[i])
      );
   end

endmodule

// File: tb/tb_adbg_toggle_sync_array.sv
// tb/tb_adbg_toggle_sync_array.sv - directed bench for adbg_toggle_sync_array (counter checks with ADBG_SYNC_EVCNT_EN)
module tb_adbg_toggle_sync_array;

   localparam int CH  = 4;
   localparam int CW  = 2;

   logic DEST_CLK = 1'b0;
   logic RESET;
   int   errors = 0;
   int   checks = 0;
   logic [CH-1:0] tog;

   adbg_toggle_sync_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

   adbg_toggle_sync_array #(
      .CHANNELS    (CH),
      .SYNC_STAGES (2),
      .CNT_W       (CW)
   ) dut (
      .DEST_CLK (DEST_CLK),
      .RESET    (RESET),
      .bus      (bus.slave)
   );

   always #5 DEST_CLK = ~DEST_CLK;

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge DEST_CLK);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tog = 4'b0101;
      bus.TOGGLE_IN = tog;
      bus.D_SET = '0;
      bus.D_RST = '0;
      repeat (2) begin
         step();
         checks++;
         if (bus.READY !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", bus.READY);
         end
         checks++;
         if ({bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW} !== 12'h000) begin
            errors++; $display("FAIL reset_outs: got %h want 000", {bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW});
         end
      end
      RESET = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (bus.READY !== (k == 2)) begin
            errors++; $display("FAIL arm_ready[%0d]: got %b want %b", k, bus.READY, (k == 2));
         end
         checks++;
         if ({bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW} !== 12'h000) begin
            errors++; $display("FAIL arm_outs[%0d]: got %h want 000", k, {bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW});
         end
      end
   endtask

   task automatic test_single_event();
      tog[0] = ~tog[0];
      bus.TOGGLE_IN = tog;
      step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0000) begin
         errors++; $display("FAIL ev_early: got %b want 0000", bus.PULSE_OUT);
      end
      step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0001 || bus.D_OUT !== 4'b0001) begin
         errors++; $display("FAIL ev_pulse: pulse %b dout %b want 0001 0001", bus.PULSE_OUT, bus.D_OUT);
      end
      step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0000 || bus.D_OUT !== 4'b0001 || bus.OVERFLOW !== 4'b0000) begin
         errors++; $display("FAIL ev_sticky: pulse %b dout %b ovf %b want 0000 0001 0000", bus.PULSE_OUT, bus.D_OUT, bus.OVERFLOW);
      end
      repeat (3) step();
      checks++;
      if (bus.D_OUT !== 4'b0001) begin
         errors++; $display("FAIL ev_hold: got %b want 0001", bus.D_OUT);
      end
`ifdef ADBG_SYNC_EVCNT_EN
      checks++;
      if (bus.EVCNT[0 +: CW] !== 2'd1) begin
         errors++; $display("FAIL ev_cnt: got %0d want 1", bus.EVCNT[0 +: CW]);
      end
`endif
      bus.D_RST = 4'b0001;
      step();
      bus.D_RST = 4'b0000;
      checks++;
      if (bus.D_OUT !== 4'b0000) begin
         errors++; $display("FAIL ev_clear: got %b want 0000", bus.D_OUT);
      end
`ifdef ADBG_SYNC_EVCNT_EN
      checks++;
      if (bus.EVCNT[0 +: CW] !== 2'd0) begin
         errors++; $display("FAIL ev_cnt_clear: got %0d want 0", bus.EVCNT[0 +: CW]);
      end
`endif
   endtask

   task automatic test_overflow();
      tog[1] = ~tog[1];
      bus.TOGGLE_IN = tog;
      step(); step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0010) begin
         errors++; $display("FAIL ovf_first: got %b want 0010", bus.PULSE_OUT);
      end
      step(); step();
      tog[1] = ~tog[1];
      bus.TOGGLE_IN = tog;
      step(); step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0010 || bus.OVERFLOW !== 4'b0000) begin
         errors++; $display("FAIL ovf_second: pulse %b ovf %b want 0010 0000", bus.PULSE_OUT, bus.OVERFLOW);
      end
      step();
      checks++;
      if (bus.OVERFLOW !== 4'b0010 || bus.D_OUT !== 4'b0010) begin
         errors++; $display("FAIL ovf_set: ovf %b dout %b want 0010 0010", bus.OVERFLOW, bus.D_OUT);
      end
      bus.D_RST = 4'b0010;
      step();
      bus.D_RST = 4'b0000;
      checks++;
      if (bus.OVERFLOW !== 4'b0000 || bus.D_OUT !== 4'b0000) begin
         errors++; $display("FAIL ovf_clear: ovf %b dout %b want 0000 0000", bus.OVERFLOW, bus.D_OUT);
      end
   endtask

   task automatic test_rst_with_det();
      tog[2] = ~tog[2];
      bus.TOGGLE_IN = tog;
      step(); step();
      checks++;
      if (bus.PULSE_OUT !== 4'b0100) begin
         errors++; $display("FAIL rdet_pulse: got %b want 0100", bus.PULSE_OUT);
      end
      bus.D_RST = 4'b0100;
      step();
      bus.D_RST = 4'b0000;
      checks++;
      if (bus.D_OUT !== 4'b0100 || bus.OVERFLOW !== 4'b0000 || bus.PULSE_OUT !== 4'b0000) begin
         errors++; $display("FAIL rdet_keep: dout %b ovf %b pulse %b want 0100 0000 0000", bus.D_OUT, bus.OVERFLOW, bus.PULSE_OUT);
      end
`ifdef ADBG_SYNC_EVCNT_EN
      checks++;
      if (bus.EVCNT[2*CW +: CW] !== 2'd1) begin
         errors++; $display("FAIL rdet_cnt: got %0d want 1", bus.EVCNT[2*CW +: CW]);
      end
`endif
      bus.D_RST = 4'b0100;
      step();
      bus.D_RST = 4'b0000;
      checks++;
      if (bus.D_OUT !== 4'b0000) begin
         errors++; $display("FAIL rdet_clear: got %b want 0000", bus.D_OUT);
      end
   endtask

   task automatic test_set_clear();
      bus.D_SET = 4'b1000;
      bus.D_RST = 4'b1000;
      step();
      checks++;
      if (bus.D_OUT !== 4'b0000) begin
         errors++; $display("FAIL setrst_both: got %b want 0000", bus.D_OUT);
      end
      bus.D_RST = 4'b0000;
      step();
      checks++;
      if (bus.D_OUT !== 4'b1000 || bus.PULSE_OUT !== 4'b0000) begin
         errors++; $display("FAIL setrst_set: dout %b pulse %b want 1000 0000", bus.D_OUT, bus.PULSE_OUT);
      end
      bus.D_SET = 4'b0000;
      step();
      checks++;
      if (bus.D_OUT !== 4'b1000) begin
         errors++; $display("FAIL setrst_hold: got %b want 1000", bus.D_OUT);
      end
      bus.D_RST = 4'b1000;
      step();
      bus.D_RST = 4'b0000;
   endtask

`ifdef ADBG_SYNC_EVCNT_EN
   task automatic test_evcnt_sat();
      for (int k = 1; k <= 5; k++) begin
         tog[0] = ~tog[0];
         bus.TOGGLE_IN = tog;
         repeat (4) step();
         checks++;
         if (bus.EVCNT[0 +: CW] !== 2'((k < 3) ? k : 3)) begin
            errors++; $display("FAIL cnt_sat[%0d]: got %0d want %0d", k, bus.EVCNT[0 +: CW], (k < 3) ? k : 3);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      bus.D_SET = 4'b1111;
      step();
      bus.D_SET = 4'b0000;
      tog = tog ^ 4'b0011;
      bus.TOGGLE_IN = tog;
      step();
      RESET = 1'b1;
      step();
      checks++;
      if (bus.READY !== 1'b0 || {bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW} !== 12'h000) begin
         errors++; $display("FAIL mid_reset: ready %b outs %h want 0 000", bus.READY, {bus.D_OUT, bus.PULSE_OUT, bus.OVERFLOW});
      end
`ifdef ADBG_SYNC_EVCNT_EN
      checks++;
      if (bus.EVCNT !== '0) begin
         errors++; $display("FAIL mid_reset_cnt: got %h want 0", bus.EVCNT);
      end
`endif
      RESET = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (bus.READY !== (k >= 2) || bus.D_OUT !== 4'b0000) begin
            errors++; $display("FAIL mid_rearm[%0d]: ready %b dout %b want %b 0000", k, bus.READY, bus.D_OUT, (k >= 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_overflow();
      test_rst_with_det();
      test_set_clear();
`ifdef ADBG_SYNC_EVCNT_EN
      test_evcnt_sat();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
